// File: rtl/vga_sync_receiver.sv
// VGA timing recovery: regenerates pixel/line counters from hsync/vsync, measures
// line and frame lengths, and tracks lock through a SEARCH..LOCKED state machine.
module vga_sync_receiver #(
    parameter int unsigned H_TOTAL      = 1344,
    parameter int unsigned H_ACTIVE     = 1024,
    parameter int unsigned H_SYNC_START = 1048,
    parameter int unsigned V_TOTAL      = 806,
    parameter int unsigned V_ACTIVE     = 768,
    parameter int unsigned V_SYNC_START = 771,
    parameter logic        SYNC_ACTIVE  = 1'b1,
    parameter int unsigned LOCK_LINES   = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        de_out,
    output logic [11:0] rgb_out,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [11:0] h_period,
    output logic [11:0] v_lines
);

    localparam int unsigned CW = 12;
    localparam int unsigned GW = (LOCK_LINES < 2) ? 1 : $clog2(LOCK_LINES + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_TOT   = CW'(H_TOTAL);
    localparam logic [CW-1:0] V_TOT   = CW'(V_TOTAL);
    localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS    = CW'(H_SYNC_START);
    localparam logic [CW-1:0] V_SS    = CW'(V_SYNC_START);
    localparam logic [CW:0]   WD_LIM  = (CW+1)'(2 * H_TOTAL);
    localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_LINES);

    typedef enum logic [2:0] {
        SEARCH  = 3'd0,
        H_LOCK  = 3'd1,
        V_ACQ   = 3'd2,
        V_CHECK = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   good_q;
    // Stored as "last sample was inactive"; reset to 0 so a sync held active
    // through reset is not mistaken for a leading edge, whatever SYNC_ACTIVE is.
    logic            hs_idle_q, vs_idle_q;
    logic [CW-1:0]   hcnt_q, vcnt_q, per_q, lines_q;
    logic [CW-1:0]   h_period_q, v_lines_q, rgb_q;
    logic            locked_q, de_q, h_err_q, v_err_q;

    logic            h_edge, v_edge, h_wrap, h_bad, v_bad, wd_hit, de_d;
    logic [CW-1:0]   hcnt_d, vcnt_d, per_d, lines_d;

    // Edge detection, counter next-state and error qualifiers.
    always_comb begin
        h_edge  = (hsync_in == SYNC_ACTIVE) && hs_idle_q;
        v_edge  = (vsync_in == SYNC_ACTIVE) && vs_idle_q;
        h_wrap  = 1'b0;
        hcnt_d  = hcnt_q + CW'(1);
        vcnt_d  = vcnt_q;
        per_d   = (per_q == CNT_MAX) ? per_q : per_q + CW'(1);
        lines_d = lines_q;

        if (h_edge) begin
            hcnt_d = H_SS;
            per_d  = CW'(1);
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            h_wrap = 1'b1;
        end

        if (v_edge) begin
            vcnt_d = V_SS;
        end else if (h_wrap) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
        end

        if (v_edge) begin
            lines_d = h_edge ? CW'(1) : '0;
        end else if (h_edge && lines_q != CNT_MAX) begin
            lines_d = lines_q + CW'(1);
        end

        h_bad  = h_edge && (per_q != H_TOT);
        v_bad  = v_edge && (lines_q != V_TOT);
        wd_hit = !h_edge && ({1'b0, per_q} >= WD_LIM);
        de_d   = (state_q == LOCKED) && (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
    end

    // Counters, measurements, lock FSM and registered outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= SEARCH;
            good_q     <= '0;
            hs_idle_q  <= 1'b0;
            vs_idle_q  <= 1'b0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            per_q      <= '0;
            lines_q    <= '0;
            h_period_q <= '0;
            v_lines_q  <= '0;
            rgb_q      <= '0;
            locked_q   <= 1'b0;
            de_q       <= 1'b0;
            h_err_q    <= 1'b0;
            v_err_q    <= 1'b0;
        end else begin
            hs_idle_q <= (hsync_in != SYNC_ACTIVE);
            vs_idle_q <= (vsync_in != SYNC_ACTIVE);
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            per_q     <= per_d;
            lines_q   <= lines_d;
            if (h_edge) h_period_q <= per_q;
            if (v_edge) v_lines_q  <= lines_q;
            locked_q  <= (state_q == LOCKED);
            de_q      <= de_d;
            rgb_q     <= de_d ? rgb_in : '0;
            h_err_q   <= 1'b0;
            v_err_q   <= 1'b0;

            case (state_q)
                SEARCH: begin
                    if (h_edge) begin
                        state_q <= H_LOCK;
                        good_q  <= '0;
                    end
                end
                H_LOCK: begin
                    if (wd_hit) begin
                        h_err_q <= 1'b1;
                        state_q <= SEARCH;
                    end else if (h_bad) begin
                        h_err_q <= 1'b1;
                        good_q  <= '0;
                    end else if (h_edge) begin
                        good_q <= GW'(good_q + 1'b1);
                        if (GW'(good_q + 1'b1) == GOOD_TGT) state_q <= V_ACQ;
                    end
                end
                V_ACQ: begin
                    if (h_bad || wd_hit) begin
                        h_err_q <= 1'b1;
                        state_q <= SEARCH;
                    end else if (v_edge) begin
                        state_q <= V_CHECK;
                    end
                end
                V_CHECK: begin
                    if (v_bad) v_err_q <= 1'b1;
                    if (h_bad || wd_hit) begin
                        h_err_q <= 1'b1;
                        state_q <= SEARCH;
                    end else if (v_edge && !v_bad) begin
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (v_bad) v_err_q <= 1'b1;
                    if (h_bad || wd_hit) h_err_q <= 1'b1;
                    if (h_bad || wd_hit || v_bad) state_q <= SEARCH;
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    assign hcount_out = hcnt_q;
    assign vcount_out = vcnt_q;
    assign de_out     = de_q;
    assign rgb_out    = rgb_q;
    assign locked     = locked_q;
    assign h_err      = h_err_q;
    assign v_err      = v_err_q;
    assign h_period   = h_period_q;
    assign v_lines    = v_lines_q;

endmodule
